// File: rtl/cart_rom_fetch.sv
// Purpose: turns a cartridge ROM read into an SDRAM req/ack fetch and returns the byte to the CPU.
//          A one-entry last-address cache serves repeat reads. Out-of-range reads and timed-out fetches return 8'hFF.
// Latency: a hit or out-of-range read stalls 1 cycle; a miss stalls 1 + ack latency; a timeout stalls TIMEOUT+1.
// Backpressure: wait_n stretches the CPU cycle while a read is pending. sdram_req is held until ack or timeout.
module cart_rom_fetch #(
  parameter int ADDR_W  = 25,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs,
  input  logic              rd,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [ADDR_W-1:0] rom_size,
  input  logic              invalidate,
  output logic [7:0]        d_to_cpu,
  output logic              wait_n,
  output logic              sdram_req,
  output logic [ADDR_W-1:0] sdram_addr,
  input  logic              sdram_ack,
  input  logic [7:0]        sdram_q,
  output logic              busy
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        d_to_cpu_q, d_to_cpu_d;
  logic              sdram_req_q, sdram_req_d;
  logic [ADDR_W-1:0] sdram_addr_q, sdram_addr_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] tag_q, tag_d;
  logic [7:0]        data_q, data_d;

  logic start;
  assign start = cs & rd;

  // State, read-data and cache registers; reset drops the request at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      d_to_cpu_q   <= 8'hFF;
      sdram_req_q  <= 1'b0;
      sdram_addr_q <= '0;
      timer_q      <= '0;
      valid_q      <= 1'b0;
      tag_q        <= '0;
      data_q       <= 8'h00;
    end else begin
      state_q      <= state_d;
      d_to_cpu_q   <= d_to_cpu_d;
      sdram_req_q  <= sdram_req_d;
      sdram_addr_q <= sdram_addr_d;
      timer_q      <= timer_d;
      valid_q      <= valid_d;
      tag_q        <= tag_d;
      data_q       <= data_d;
    end
  end

  // Next-state logic: range check, then cache lookup, then fetch with an ack-or-timeout exit.
  always_comb begin
    state_d      = state_q;
    d_to_cpu_d   = d_to_cpu_q;
    sdram_req_d  = sdram_req_q;
    sdram_addr_d = sdram_addr_q;
    timer_d      = timer_q;
    valid_d      = valid_q;
    tag_d        = tag_q;
    data_d       = data_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (mem_addr >= rom_size) begin
            d_to_cpu_d = 8'hFF;
            state_d    = DONE;
          end else if (valid_q && (tag_q == mem_addr)) begin
            d_to_cpu_d = data_q;
            state_d    = DONE;
          end else begin
            sdram_req_d  = 1'b1;
            sdram_addr_d = mem_addr;
            timer_d      = '0;
            state_d      = FETCH;
          end
        end
      end
      FETCH: begin
        timer_d = timer_q + TW'(1);
        // An ack on the final timer cycle still delivers real data.
        if (sdram_ack) begin
          d_to_cpu_d  = sdram_q;
          tag_d       = sdram_addr_q;
          data_d      = sdram_q;
          valid_d     = 1'b1;
          sdram_req_d = 1'b0;
          state_d     = DONE;
        end else if (timer_q == TIMER_LAST) begin
          d_to_cpu_d  = 8'hFF;
          sdram_req_d = 1'b0;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (!rd || !cs) state_d = IDLE;
      end
      default: begin
        state_d     = IDLE;
        sdram_req_d = 1'b0;
      end
    endcase
    // Invalidate overrides a same-cycle fill so stale data is never served.
    if (invalidate) valid_d = 1'b0;
  end

  // Stall the CPU on a fresh start in IDLE and for the whole fetch. Reset suppresses the stall.
  always_comb begin
    wait_n = ~(((state_q == IDLE) & start & ~reset) | (state_q == FETCH));
  end

  assign d_to_cpu   = d_to_cpu_q;
  assign sdram_req  = sdram_req_q;
  assign sdram_addr = sdram_addr_q;
  assign busy       = (state_q == FETCH);

endmodule

// File: tb/tb_cart_rom_fetch.sv
// Purpose: directed self-checking bench for cart_rom_fetch.
// Covers hits, misses, out-of-range reads, timeout, ack/invalidate races and reset mid-fetch.
// Each read ends with rd and cs dropped, so the DUT returns to IDLE before the next read.
module tb_cart_rom_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs, rd, invalidate, sdram_ack;
  logic [24:0] mem_addr, rom_size;
  logic [7:0]  sdram_q;
  logic [7:0]  d_to_cpu;
  logic        wait_n, sdram_req, busy;
  logic [24:0] sdram_addr;

  int checks = 0;
  int errors = 0;

  int          low, reqc;
  bit          addr_bad;
  logic [7:0]  dout;

  always #5 clk = ~clk;

  cart_rom_fetch #(.ADDR_W(25), .TIMEOUT(64)) dut (
    .clk        (clk),
    .reset      (reset),
    .cs         (cs),
    .rd         (rd),
    .mem_addr   (mem_addr),
    .rom_size   (rom_size),
    .invalidate (invalidate),
    .d_to_cpu   (d_to_cpu),
    .wait_n     (wait_n),
    .sdram_req  (sdram_req),
    .sdram_addr (sdram_addr),
    .sdram_ack  (sdram_ack),
    .sdram_q    (sdram_q),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One CPU read. Acks on the ack_at-th request cycle (0 = never ack).
  // Reports the stall length, the request cycles and the returned byte.
  task automatic do_read(input logic [24:0] a, input int ack_at, input logic [7:0] q,
                         input bit inv, output int lo, output int rq,
                         output bit bad, output logic [7:0] d);
    lo = 0; rq = 0; bad = 1'b0;
    @(negedge clk);
    cs = 1'b1; rd = 1'b1; mem_addr = a;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (wait_n === 1'b1) break;
      lo++;
      if (sdram_req === 1'b1) begin
        rq++;
        if (sdram_addr !== a) bad = 1'b1;
        if (rq == ack_at) begin
          sdram_ack = 1'b1; sdram_q = q; invalidate = inv;
        end
      end
      @(negedge clk);
      sdram_ack = 1'b0; invalidate = 1'b0;
    end
    d = d_to_cpu;
    cs = 1'b0; rd = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; cs = 1'b0; rd = 1'b0; invalidate = 1'b0; sdram_ack = 1'b0;
    mem_addr = '0; rom_size = 25'd32768; sdram_q = 8'h00;
    #1;
    chk("rst_d", {24'h0, d_to_cpu}, 32'hFF);
    chk("rst_req", {31'h0, sdram_req}, 32'h0);
    chk("rst_addr", {7'h0, sdram_addr}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_wait", {31'h0, wait_n}, 32'h1);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    // Miss with an ack on the third fetch cycle.
    do_read(25'h0010, 3, 8'h41, 1'b0, low, reqc, addr_bad, dout);
    chk("miss_low", low, 4);
    chk("miss_reqc", reqc, 3);
    chk("miss_addr", {31'h0, addr_bad}, 32'h0);
    chk("miss_d", {24'h0, dout}, 32'h41);
    #1;
    chk("miss_idle_busy", {31'h0, busy}, 32'h0);
    chk("miss_idle_wait", {31'h0, wait_n}, 32'h1);

    // Repeat the read for a hit, then invalidate and miss again.
    do_read(25'h0010, 1, 8'hEE, 1'b0, low, reqc, addr_bad, dout);
    chk("hit_low", low, 1);
    chk("hit_reqc", reqc, 0);
    chk("hit_d", {24'h0, dout}, 32'h41);
    @(negedge clk); invalidate = 1'b1;
    @(negedge clk); invalidate = 1'b0;
    do_read(25'h0010, 2, 8'h42, 1'b0, low, reqc, addr_bad, dout);
    chk("inv_reqc", reqc, 2);
    chk("inv_low", low, 3);
    chk("inv_d", {24'h0, dout}, 32'h42);

    // Out-of-range reads at the boundary, last in-range byte, and with no image loaded.
    do_read(25'h8000, 1, 8'hEE, 1'b0, low, reqc, addr_bad, dout);
    chk("oor_low", low, 1);
    chk("oor_reqc", reqc, 0);
    chk("oor_d", {24'h0, dout}, 32'hFF);
    do_read(25'h7FFF, 1, 8'h7E, 1'b0, low, reqc, addr_bad, dout);
    chk("last_low", low, 2);
    chk("last_d", {24'h0, dout}, 32'h7E);
    rom_size = 25'd0;
    do_read(25'h0000, 1, 8'hEE, 1'b0, low, reqc, addr_bad, dout);
    chk("empty_reqc", reqc, 0);
    chk("empty_d", {24'h0, dout}, 32'hFF);
    do_read(25'h7FFF, 1, 8'hEE, 1'b0, low, reqc, addr_bad, dout);
    chk("empty_cached_low", low, 1);
    chk("empty_cached_d", {24'h0, dout}, 32'hFF);
    rom_size = 25'd32768;

    // Timeout with no ack, then the same address must still miss.
    do_read(25'h0123, 0, 8'hEE, 1'b0, low, reqc, addr_bad, dout);
    chk("to_reqc", reqc, 64);
    chk("to_low", low, 65);
    chk("to_d", {24'h0, dout}, 32'hFF);
    do_read(25'h0123, 1, 8'h33, 1'b0, low, reqc, addr_bad, dout);
    chk("to_remiss_reqc", reqc, 1);
    chk("to_remiss_d", {24'h0, dout}, 32'h33);

    // Ack together with invalidate returns the data but leaves the cache empty.
    do_read(25'h0200, 2, 8'h5A, 1'b1, low, reqc, addr_bad, dout);
    chk("ackinv_d", {24'h0, dout}, 32'h5A);
    do_read(25'h0200, 1, 8'h11, 1'b0, low, reqc, addr_bad, dout);
    chk("ackinv_remiss_reqc", reqc, 1);
    chk("ackinv_remiss_d", {24'h0, dout}, 32'h11);

    // An ack on the final timer cycle wins over the timeout.
    do_read(25'h0300, 64, 8'h5A, 1'b0, low, reqc, addr_bad, dout);
    chk("acklast_low", low, 65);
    chk("acklast_d", {24'h0, dout}, 32'h5A);
    do_read(25'h0300, 1, 8'hEE, 1'b0, low, reqc, addr_bad, dout);
    chk("acklast_hit_reqc", reqc, 0);
    chk("acklast_hit_d", {24'h0, dout}, 32'h5A);

    // Reset during a fetch; a late ack must be ignored.
    @(negedge clk);
    cs = 1'b1; rd = 1'b1; mem_addr = 25'h0400;
    repeat (3) @(negedge clk);
    #1;
    chk("rstf_pre_req", {31'h0, sdram_req}, 32'h1);
    reset = 1'b1;
    #1;
    chk("rstf_req", {31'h0, sdram_req}, 32'h0);
    chk("rstf_d", {24'h0, d_to_cpu}, 32'hFF);
    chk("rstf_wait", {31'h0, wait_n}, 32'h1);
    chk("rstf_busy", {31'h0, busy}, 32'h0);
    @(negedge clk);
    reset = 1'b0; cs = 1'b0; rd = 1'b0;
    sdram_ack = 1'b1; sdram_q = 8'h99;
    @(negedge clk);
    sdram_ack = 1'b0;
    #1;
    chk("late_ack_req", {31'h0, sdram_req}, 32'h0);
    chk("late_ack_busy", {31'h0, busy}, 32'h0);
    chk("late_ack_d", {24'h0, d_to_cpu}, 32'hFF);
    do_read(25'h0300, 1, 8'h66, 1'b0, low, reqc, addr_bad, dout);
    chk("rst_cache_clr_reqc", reqc, 1);
    chk("rst_cache_clr_d", {24'h0, dout}, 32'h66);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
